// File: rtl/rx_mac_buffer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : rx_mac_buffer_pkg
// Brief    : Shared widths, types and byte-lane helper for the Rx MAC buffer.
// Revision : 1.0 - initial release
// ============================================================================
package rx_mac_buffer_pkg;

    localparam int RX_BUF_AW     = 12;
    localparam int RX_HOST_AW    = 11;
    localparam int RX_HOST_DW    = 16;
    localparam int RX_HOST_WORDS = 1 << RX_HOST_AW;

    typedef logic [RX_HOST_DW-1:0] rx_word_t;

    // Network byte order: the even byte of a pair lands in the upper lane.
    function automatic logic [1:0] rx_lane_be(input logic a0);
        return a0 ? 2'b01 : 2'b10;
    endfunction

endpackage : rx_mac_buffer_pkg
`default_nettype wire

// File: rtl/rx_buf_dpram.sv
`default_nettype none
// ============================================================================
// Module   : rx_buf_dpram
// Brief    : 2048x16 RAM, byte-enabled write port, registered read-first read.
// Revision : 1.0 - initial release
// ============================================================================
module rx_buf_dpram
    import rx_mac_buffer_pkg::*;
#(
    parameter int INIT_ZERO = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_en_i,
    input  logic [RX_HOST_AW-1:0] wr_addr_i,
    input  logic [1:0]            wr_be_i,
    input  rx_word_t              wr_data_i,
    input  logic [RX_HOST_AW-1:0] rd_addr_i,
    output rx_word_t              rd_data_o
);

    // Power-up contents come from the implementation flow's memory init;
    // INIT_ZERO records whether that flow must zero-fill the array.
    if ((INIT_ZERO != 0) && (INIT_ZERO != 1)) begin : g_init_zero_check
        $error("rx_buf_dpram: INIT_ZERO must be 0 or 1");
    end

    rx_word_t mem_q [0:RX_HOST_WORDS-1];
    rx_word_t rd_data_q;

    always @(posedge clk) begin
        if (wr_en_i) begin
            if (wr_be_i[1]) mem_q[wr_addr_i][15:8] <= wr_data_i[15:8];
            if (wr_be_i[0]) mem_q[wr_addr_i][7:0]  <= wr_data_i[7:0];
        end
    end

    // Separate process from the write: a same-edge collision returns old data.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_data_q <= '0;
        end else begin
            rd_data_q <= mem_q[rd_addr_i];
        end
    end

    assign rd_data_o = rd_data_q;

endmodule : rx_buf_dpram
`default_nettype wire

// File: rtl/rx_mac_buffer.sv
`default_nettype none
// ============================================================================
// Module   : rx_mac_buffer
// Brief    : Rx packet buffer (byte writes from MAC, word reads from host)
//            with end-of-packet status accept filter.
// Revision : 1.0 - initial release
// ============================================================================
module rx_mac_buffer
    import rx_mac_buffer_pkg::*;
#(
    parameter logic [7:0] ACCEPT_MASK  = 8'hff,
    parameter logic [7:0] ACCEPT_MATCH = 8'h00,
    parameter int         INIT_ZERO    = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [RX_HOST_AW-1:0] host_raddr,
    output logic [RX_HOST_DW-1:0] host_rdata,
    input  logic [7:0]            rx_mac_d,
    input  logic [RX_BUF_AW-1:0]  rx_mac_a,
    input  logic                  rx_mac_wen,
    input  logic [7:0]            rx_mac_status_d,
    input  logic                  rx_mac_status_s,
    output logic                  rx_mac_accept
);

    logic     wr_en;
    logic     accept_d;
    logic     accept_q;
    rx_word_t rdata;

    assign wr_en = rx_mac_wen & rst_n;

    rx_buf_dpram #(
        .INIT_ZERO (INIT_ZERO)
    ) u_dpram (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr_en_i   (wr_en),
        .wr_addr_i (rx_mac_a[RX_BUF_AW-1:1]),
        .wr_be_i   (rx_lane_be(rx_mac_a[0])),
        .wr_data_i ({rx_mac_d, rx_mac_d}),
        .rd_addr_i (host_raddr),
        .rd_data_o (rdata)
    );

    assign accept_d = rx_mac_status_s &&
                      ((rx_mac_status_d & ACCEPT_MASK) == ACCEPT_MATCH);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            accept_q <= 1'b0;
        end else begin
            accept_q <= accept_d;
        end
    end

    assign rx_mac_accept = accept_q;
    assign host_rdata    = rdata;

endmodule : rx_mac_buffer
`default_nettype wire

// File: tb/tb_rx_mac_buffer.sv
`default_nettype none
// ============================================================================
// Module   : tb_rx_mac_buffer
// Brief    : Scoreboard bench for rx_mac_buffer with a byte-array model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rx_mac_buffer;

    logic        clk;
    logic        rst_n;
    logic [10:0] host_raddr;
    logic [15:0] host_rdata;
    logic [7:0]  rx_mac_d;
    logic [11:0] rx_mac_a;
    logic        rx_mac_wen;
    logic [7:0]  rx_mac_status_d;
    logic        rx_mac_status_s;
    logic        rx_mac_accept;

    rx_mac_buffer #(
        .ACCEPT_MASK  (8'h0F),
        .ACCEPT_MATCH (8'h03),
        .INIT_ZERO    (1)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .host_raddr      (host_raddr),
        .host_rdata      (host_rdata),
        .rx_mac_d        (rx_mac_d),
        .rx_mac_a        (rx_mac_a),
        .rx_mac_wen      (rx_mac_wen),
        .rx_mac_status_d (rx_mac_status_d),
        .rx_mac_status_s (rx_mac_status_s),
        .rx_mac_accept   (rx_mac_accept)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit          chk_rd;
        logic [15:0] rd;
        bit          acc;
        string       tag;
    } exp_t;

    exp_t        exp_q[$];
    logic [7:0]  mbyte [0:4095];
    bit          mknown[0:4095];
    int          checks = 0;
    int          errors = 0;

    // One clock of stimulus; the model's prediction for that edge is queued.
    task automatic cyc(input bit rn, input bit wen, input logic [11:0] a,
                       input logic [7:0] d, input bit ss, input logic [7:0] sd,
                       input logic [10:0] ra, input string tag);
        exp_t e;
        @(negedge clk);
        rst_n           = rn;
        rx_mac_wen      = wen;
        rx_mac_a        = a;
        rx_mac_d        = d;
        rx_mac_status_s = ss;
        rx_mac_status_d = sd;
        host_raddr      = ra;
        e.tag = tag;
        if (!rn) begin
            e.chk_rd = 1'b1;
            e.rd     = 16'h0000;
            e.acc    = 1'b0;
        end else begin
            e.chk_rd = mknown[{ra, 1'b0}] && mknown[{ra, 1'b1}];
            e.rd     = {mbyte[{ra, 1'b0}], mbyte[{ra, 1'b1}]};
            e.acc    = ss && (sd[3:0] == 4'h3);
            if (wen) begin
                mbyte[a]  = d;
                mknown[a] = 1'b1;
            end
        end
        exp_q.push_back(e);
    endtask

    task automatic wr(input logic [11:0] a, input logic [7:0] d, input string tag);
        cyc(1'b1, 1'b1, a, d, 1'b0, 8'h00, 11'h000, tag);
    endtask

    task automatic rd(input logic [10:0] ra, input string tag);
        cyc(1'b1, 1'b0, 12'h000, 8'h00, 1'b0, 8'h00, ra, tag);
    endtask

    task automatic st(input logic [7:0] sd, input string tag);
        cyc(1'b1, 1'b0, 12'h000, 8'h00, 1'b1, sd, 11'h000, tag);
    endtask

    // Monitor: the DUT presents both outputs after every edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checks++;
                if (rx_mac_accept !== e.acc) begin
                    errors++;
                    $display("FAIL %s accept got %b want %b", e.tag, rx_mac_accept, e.acc);
                end
                if (e.chk_rd) begin
                    checks++;
                    if (host_rdata !== e.rd) begin
                        errors++;
                        $display("FAIL %s rdata got %h want %h", e.tag, host_rdata, e.rd);
                    end
                end
            end
        end
    end

    initial begin
        for (int i = 0; i < 4096; i++) begin
            mbyte[i]  = 8'h00;
            mknown[i] = 1'b0;
        end
        rst_n = 1'b0; rx_mac_wen = 1'b0; rx_mac_a = '0; rx_mac_d = '0;
        rx_mac_status_s = 1'b0; rx_mac_status_d = '0; host_raddr = '0;

        cyc(1'b0, 1'b0, 12'h000, 8'h00, 1'b0, 8'h00, 11'h000, "por");
        cyc(1'b0, 1'b0, 12'h000, 8'h00, 1'b0, 8'h00, 11'h000, "por");

        // Preload word 0, then reset with write and status activity.
        wr(12'h000, 8'hC3, "pre_hi");
        wr(12'h001, 8'hA5, "pre_lo");
        for (int i = 0; i < 4; i++)
            cyc(1'b0, 1'b1, 12'h000, 8'hEE, 1'b1, 8'h03, 11'h000, "rst_hold");
        rd(11'h000, "rst_word0");

        wr(12'h000, 8'h12, "pack_hi");
        wr(12'h001, 8'h34, "pack_lo");
        rd(11'h000, "pack_rd");

        wr(12'hFFE, 8'h5A, "top_hi");
        rd(11'h7FF, "top_part");
        wr(12'hFFF, 8'hAB, "top_lo");
        rd(11'h7FF, "top_rd");
        rd(11'h000, "top_w0");

        wr(12'h00A, 8'h11, "col_pre_hi");
        wr(12'h00B, 8'h11, "col_pre_lo");
        cyc(1'b1, 1'b1, 12'h00A, 8'h22, 1'b0, 8'h00, 11'h005, "col_same");
        rd(11'h005, "col_next");

        st(8'h13, "flt_13");
        rd(11'h000, "flt_13_end");
        st(8'h14, "flt_14");
        rd(11'h000, "flt_14_end");
        st(8'h03, "flt_b2b_1");
        st(8'h04, "flt_b2b_0");
        rd(11'h000, "flt_b2b_end");

        // Write concurrent with status strobe.
        cyc(1'b1, 1'b1, 12'h100, 8'h77, 1'b1, 8'hF3, 11'h000, "wr_and_st");
        rd(11'h080, "wr_and_st_rd");

        for (int i = 0; i < 64; i++) wr(12'(i), 8'(i), "stream_wr");
        for (int k = 0; k < 32; k++) rd(11'(k), "stream_rd");

        for (int n = 0; n < 400; n++) begin
            bit          rn;
            logic [11:0] a;
            logic [7:0]  sd;
            logic [10:0] ra;
            rn = ($urandom_range(0, 39) != 0);
            a  = ($urandom_range(0, 3) == 0) ? 12'($urandom) : 12'($urandom_range(0, 255));
            sd = 8'($urandom);
            if ($urandom_range(0, 1) == 1) sd[3:0] = 4'h3;
            ra = ($urandom_range(0, 7) == 0) ? 11'h7FF : 11'($urandom_range(0, 127));
            cyc(rn, 1'($urandom), a, 8'($urandom), 1'($urandom), sd, ra, "rand");
        end
        rd(11'h000, "tail");

        begin
            int budget;
            budget = 0;
            while (exp_q.size() > 0 && budget < 20) begin
                @(posedge clk);
                budget++;
            end
            @(posedge clk);
            #2;
            if (exp_q.size() > 0) begin
                errors++;
                $display("FAIL drain pending got %0d want 0", exp_q.size());
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_rx_mac_buffer
`default_nettype wire

// File: doc/rx_mac_buffer.md
Name: rx_mac_buffer

Overview:
- Receive-side packet buffer between the Ethernet Rx MAC byte stream and the local-bus host.
- The MAC engine writes received packet bytes into a 4 KiB buffer, one byte per write.
- The host reads the same buffer as 2048 16-bit words.
- A status filter inspects each end-of-packet status byte and returns a one-cycle accept pulse to the MAC engine for packets matching a programmable class; the accept pulse releases the buffer bank.

Parameters:
- accept_mask, 8'hff, status bits that participate in the accept decision.
- accept_match, 8'h00, required value of (status_d & accept_mask) for acceptance.
- init_zero, 1, when 1 the memory powers up all-zero (simulation/FPGA init); when 0 it is undefined.

Ports:
- clk  input  1  single clock for host and MAC sides.
- rst_n  input  1  synchronous reset, active low.
- host_raddr  input  11  host word address.
- host_rdata  output  16  host read data, registered.
- rx_mac_d  input  8  byte to write.
- rx_mac_a  input  12  byte address.
- rx_mac_wen  input  1  byte write strobe.
- rx_mac_status_d  input  8  end-of-packet status byte.
- rx_mac_status_s  input  1  status valid strobe, one cycle.
- rx_mac_accept  output  1  accept pulse to the MAC engine.

Behaviour:
- Clock and reset: one clock, clk; reset is synchronous and active-low, rst_n.
- Reset values: host_rdata=0, rx_mac_accept=0. Memory contents are not cleared by reset.
- Storage: 2048 x 16 array, byte-addressed on the write side.
- Byte-lane mapping (network order):
  - rx_mac_a[11:1] selects the word.
  - rx_mac_a[0]=0 writes bits [15:8]; rx_mac_a[0]=1 writes bits [7:0].
  - The other byte lane of the word is preserved.
- Write timing: a write occurs on the clk edge where rx_mac_wen=1 and rst_n=1. Writes are ignored while rst_n=0.
- Read timing:
  - host_rdata <= mem[host_raddr] every cycle when rst_n=1, giving 1-cycle latency.
  - Address is sampled at edge N; data is valid after edge N.
- Read/write collision (same word, same edge): read-first, so host_rdata returns the pre-write contents. The new value is visible on the next read.
- Accept filter:
  - On an edge with rx_mac_status_s=1, rx_mac_accept <= ((rx_mac_status_d & accept_mask) == accept_match).
  - Otherwise rx_mac_accept <= 0.
  - Result: a one-cycle pulse, 1 cycle after the status strobe. Back-to-back strobes give back-to-back independent decisions.
- Status strobe during reset: ignored, accept stays 0.
- Address wrap: rx_mac_a covers the full 4096-byte space. There is no bounds check and no overflow flag.
- Write concurrent with status strobe: both take effect; they are independent.
- The block is pure datapath. It has no FSM and no packet-length tracking; bank/half-buffer management (hbank, buf_status) is owned by the MAC engine.

Decomposition:
- Shared package: constants RX_BUF_AW=12 (byte address width), RX_HOST_AW=11, RX_HOST_DW=16.
- One sub-module is natural: rx_buf_dpram, a 2048x16 RAM with a byte-enabled write port and a registered read-first read port, written so it infers block RAM.
- The status filter and reset logic stay in the top level.

Test Plan:
- Reset: hold rst_n=0 for 4 cycles with wen=1 to address 0 and status_s=1. -> accept=0, host_rdata=0 throughout; word 0 unchanged after reset.
- Byte packing: write 0x12 @a=0x000 and 0x34 @a=0x001, then read raddr=0. -> host_rdata=0x1234 one cycle later.
- Partial update and top address: write 0xAB @a=0xFFF (word 2047 low byte) with high byte 0x5A written earlier. -> raddr=0x7FF reads 0x5AAB; word 0 unaffected.
- Collision: word 5 holds 0x1111; on one edge, read raddr=5 and write 0x22 @a=0x00A. -> that read gives 0x1111; the next read gives 0x2211.
- Filter (mask=0x0F, match=0x03): status 0x13 strobe -> accept pulse exactly 1 cycle later, width 1. Status 0x14 -> no pulse. Strobes 0x03 then 0x04 on consecutive cycles -> pattern 1,0.
- Streaming: write 64 sequential bytes 0x00..0x3F, then sweep reads over words 0..31. -> word k reads {2k, 2k+1}.
